// File: rtl/load_store_unit.sv
// load_store_unit: RV32I data-memory access sequencer with sub-word loads and read-modify-write stores
module load_store_unit #(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic        clk_lsu,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        Mem_Write,
    output logic [31:0] DM_Addr,
    output logic [31:0] M_W_Data,
    input  logic [31:0] M_R_Data
);
    typedef enum logic [2:0] {IDLE, RD, WR, RESP, ERR} state_t;
    state_t      state_q, state_d;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  lo_q;
    logic [15:0] wd_q;
    logic [31:0] rdata_q, rdata_d, dm_addr_q, dm_addr_d, wword_q, wword_d;
    logic [31:0] load_v, merged;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        bad, is_sw, unused_hi;
    assign unused_hi = ^addr[31:DEPTH_LOG2+2];
    assign is_sw = we && funct3 == 3'b010;
    assign bad = (funct3[1:0] == 2'b11) | (funct3[2] & (we | funct3[1]))
               | (funct3[1:0] == 2'b01 & addr[0]) | (funct3[1:0] == 2'b10 & addr[1:0] != 2'b00);
    assign ready = state_q == IDLE;
    assign rvalid = state_q == RESP;
    assign misaligned = state_q == ERR;
    assign Mem_Write = state_q == WR;
    assign rdata = rdata_q;
    assign DM_Addr = dm_addr_q;
    assign M_W_Data = wword_q;
    // Lane extraction for loads and lane replacement for sub-word stores
    always_comb begin
        byte_v = M_R_Data[{lo_q, 3'b000} +: 8];
        half_v = M_R_Data[{lo_q[1], 4'b0000} +: 16];
        load_v = f3_q[1] ? M_R_Data
               : f3_q[0] ? {{16{~f3_q[2] & half_v[15]}}, half_v}
               : {{24{~f3_q[2] & byte_v[7]}}, byte_v};
        merged = M_R_Data;
        if (f3_q[0]) merged[{lo_q[1], 4'b0000} +: 16] = wd_q;
        else merged[{lo_q, 3'b000} +: 8] = wd_q[7:0];
    end
    // Next-state and datapath register updates
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        dm_addr_d = dm_addr_q;
        wword_d = wword_q;
        case (state_q)
            IDLE: if (req) begin
                if (bad) state_d = ERR;
                else begin
                    state_d = is_sw ? WR : RD;
                    dm_addr_d = 32'(addr[DEPTH_LOG2+1:2]);
                    if (is_sw) wword_d = wdata;
                end
            end
            RD: if (we_q) begin
                state_d = WR;
                wword_d = merged;
            end else begin
                state_d = RESP;
                rdata_d = load_v;
            end
            default: state_d = IDLE;
        endcase
    end
    // State and datapath registers
    always_ff @(posedge clk_lsu or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rdata_q <= '0;
            dm_addr_q <= '0;
            wword_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            dm_addr_q <= dm_addr_d;
            wword_q <= wword_d;
        end
    end
    // Request capture so later input changes cannot disturb an access in flight
    always_ff @(posedge clk_lsu or negedge rst_n) begin
        if (!rst_n) begin
            we_q <= 1'b0;
            f3_q <= '0;
            lo_q <= '0;
            wd_q <= '0;
        end else if (req && state_q == IDLE) begin
            we_q <= we;
            f3_q <= funct3;
            lo_q <= addr[1:0];
            wd_q <= wdata[15:0];
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven scoreboard bench for load_store_unit with a word-addressed memory model
module tb_load_store_unit;
    logic        clk_lsu = 1'b0, rst_n = 1'b0, req = 1'b0, we = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0, wdata = '0;
    logic        ready, rvalid, misaligned, Mem_Write;
    logic [31:0] rdata, DM_Addr, M_W_Data, M_R_Data;
    int n_chk = 0, n_fail = 0, cyc = 0;
    logic [31:0] last_rd = '0;
    logic        mem_init = 1'b0;
    logic [31:0] mem [256];

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, wdata;
        int          kind;
        logic [31:0] val, daddr;
        int          lat;
    } vec_t;
    typedef struct {
        string       name;
        int          kind;
        logic [31:0] val, daddr;
        int          lat, acc;
    } exp_t;
    vec_t tv [26];
    exp_t q [$];

    load_store_unit #(.DEPTH_LOG2(8)) dut (
        .clk_lsu(clk_lsu), .rst_n(rst_n), .req(req), .we(we), .funct3(funct3),
        .addr(addr), .wdata(wdata), .ready(ready), .rvalid(rvalid), .rdata(rdata),
        .misaligned(misaligned), .Mem_Write(Mem_Write), .DM_Addr(DM_Addr),
        .M_W_Data(M_W_Data), .M_R_Data(M_R_Data)
    );

    always #5 clk_lsu = ~clk_lsu;
    always @(posedge clk_lsu) cyc <= cyc + 1;

    assign M_R_Data = mem[DM_Addr[7:0]];
    always @(posedge clk_lsu) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= i;
            mem_init <= 1'b1;
        end else if (Mem_Write) mem[DM_Addr[7:0]] <= M_W_Data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk_lsu) begin
        if (rst_n && (Mem_Write || rvalid || misaligned)) begin
            if ($countones({Mem_Write, rvalid, misaligned}) != 1 || q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_event: mw=%0b rv=%0b mis=%0b queued=%0d", Mem_Write, rvalid, misaligned, q.size());
            end else begin
                exp_t e;
                int k;
                e = q.pop_front();
                k = Mem_Write ? 1 : rvalid ? 0 : 2;
                chk({e.name, "_kind"}, k, e.kind);
                chk({e.name, "_latency"}, cyc - e.acc + 1, e.lat);
                if (k == 0) chk({e.name, "_rdata"}, rdata, e.val);
                if (k == 1) begin
                    chk({e.name, "_wdata"}, M_W_Data, e.val);
                    chk({e.name, "_dmaddr"}, DM_Addr, e.daddr);
                end
            end
        end
    end

    task automatic do_vec(input vec_t v);
        req = 1'b1; we = v.we; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
        q.push_back('{v.name, v.kind, v.val, v.daddr, v.lat, cyc + 1});
        @(negedge clk_lsu); #1;
        req = 1'b0; we = ~v.we; funct3 = 3'b111; addr = ~v.addr; wdata = ~v.wdata;
        for (int i = 0; i < 8 && q.size() != 0; i++) begin
            @(negedge clk_lsu); #1;
        end
        if (q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: got no response, expected one within 8 cycles", v.name);
            q.delete();
        end
        @(negedge clk_lsu); #1;
        chk({v.name, "_ready_after"}, ready, 1);
        if (v.kind == 0) last_rd = v.val;
        else chk({v.name, "_rdata_hold"}, rdata, last_rd);
    endtask

    initial begin
        tv[0]  = '{"sw_10",   1, 3'b010, 32'h10,  32'h8899AABB, 1, 32'h8899AABB, 4,   1};
        tv[1]  = '{"lb_11",   0, 3'b000, 32'h11,  0,            0, 32'hFFFFFFAA, 0,   2};
        tv[2]  = '{"lbu_11",  0, 3'b100, 32'h11,  0,            0, 32'h000000AA, 0,   2};
        tv[3]  = '{"lh_12",   0, 3'b001, 32'h12,  0,            0, 32'hFFFF8899, 0,   2};
        tv[4]  = '{"lhu_12",  0, 3'b101, 32'h12,  0,            0, 32'h00008899, 0,   2};
        tv[5]  = '{"sb_13",   1, 3'b000, 32'h13,  32'h12345655, 1, 32'h5599AABB, 4,   2};
        tv[6]  = '{"sh_10",   1, 3'b001, 32'h10,  32'h0000BEEF, 1, 32'h5599BEEF, 4,   2};
        tv[7]  = '{"lw_10",   0, 3'b010, 32'h10,  0,            0, 32'h5599BEEF, 0,   2};
        tv[8]  = '{"lw_06",   0, 3'b010, 32'h06,  0,            2, 0,            0,   1};
        tv[9]  = '{"sh_05",   1, 3'b001, 32'h05,  32'hFFFF,     2, 0,            0,   1};
        tv[10] = '{"f3_011",  0, 3'b011, 32'h00,  0,            2, 0,            0,   1};
        tv[11] = '{"st_f100", 1, 3'b100, 32'h00,  32'h1,        2, 0,            0,   1};
        tv[12] = '{"lh_03",   0, 3'b001, 32'h03,  0,            2, 0,            0,   1};
        tv[13] = '{"lw_04a",  0, 3'b010, 32'h04,  0,            0, 32'h00000001, 0,   2};
        tv[14] = '{"sw_404",  1, 3'b010, 32'h404, 32'hCAFEF00D, 1, 32'hCAFEF00D, 1,   1};
        tv[15] = '{"lw_04b",  0, 3'b010, 32'h04,  0,            0, 32'hCAFEF00D, 0,   2};
        tv[16] = '{"lb_200",  0, 3'b000, 32'h200, 0,            0, 32'hFFFFFF80, 0,   2};
        tv[17] = '{"lbu_200", 0, 3'b100, 32'h200, 0,            0, 32'h00000080, 0,   2};
        tv[18] = '{"sw_3fc",  1, 3'b010, 32'h3FC, 32'h0000807F, 1, 32'h0000807F, 255, 1};
        tv[19] = '{"lh_3fc",  0, 3'b001, 32'h3FC, 0,            0, 32'hFFFF807F, 0,   2};
        tv[20] = '{"lhu_3fc", 0, 3'b101, 32'h3FC, 0,            0, 32'h0000807F, 0,   2};
        tv[21] = '{"lb_3ff",  0, 3'b000, 32'h3FF, 0,            0, 32'h00000000, 0,   2};
        tv[22] = '{"sh_3fe",  1, 3'b001, 32'h3FE, 32'hABCD8001, 1, 32'h8001807F, 255, 2};
        tv[23] = '{"lw_3fc",  0, 3'b010, 32'h3FC, 0,            0, 32'h8001807F, 0,   2};
        tv[24] = '{"lh_3fe",  0, 3'b001, 32'h3FE, 0,            0, 32'hFFFF8001, 0,   2};
        tv[25] = '{"lw_7fc",  0, 3'b010, 32'h7FC, 0,            0, 32'h8001807F, 0,   2};
        repeat (2) @(negedge clk_lsu);
        #1;
        chk("rst_ready", ready, 1);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_misaligned", misaligned, 0);
        chk("rst_memwrite", Mem_Write, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_dmaddr", DM_Addr, 0);
        chk("rst_mwdata", M_W_Data, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 26; i++) do_vec(tv[i]);
        chk("mem_word4", mem[4], 32'h5599BEEF);
        chk("mem_word1", mem[1], 32'hCAFEF00D);
        // SB aborted by reset while in RD
        req = 1'b1; we = 1'b1; funct3 = 3'b000; addr = 32'h20; wdata = 32'hAB;
        @(negedge clk_lsu); #1;
        req = 1'b0;
        chk("abort_rd_dmaddr", DM_Addr, 8);
        chk("abort_rd_ready", ready, 0);
        rst_n = 1'b0;
        #1;
        chk("abort_rd_ready_in_rst", ready, 1);
        chk("abort_rd_rdata_rst", rdata, 0);
        chk("abort_rd_dmaddr_rst", DM_Addr, 0);
        @(negedge clk_lsu); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_lsu); #1;
            chk("abort_rd_no_write", Mem_Write, 0);
        end
        chk("abort_rd_mem8", mem[8], 32'h8);
        chk("abort_rd_ready_after", ready, 1);
        // SW aborted by reset while in WR, before its write edge
        req = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'h24; wdata = 32'hDEADBEEF;
        @(posedge clk_lsu); #1;
        req = 1'b0;
        chk("abort_wr_memwrite_pre", Mem_Write, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_wr_memwrite_rst", Mem_Write, 0);
        @(negedge clk_lsu); #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk_lsu);
        #1;
        chk("abort_wr_mem9", mem[9], 32'h9);
        last_rd = '0;
        do_vec('{"lw_20_post", 0, 3'b010, 32'h20, 0, 0, 32'h00000008, 0, 2});
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
